run_length_detector: RTL and testbench
======================================

// Module: run_length_detector
// PURPOSE
// - Serial detector on input j: flags a frame "0, exactly L ones, 0", where L is a runtime length up to MAX_RUN.
// - Alarm w is sticky until acknowledged on en. Saturating hit counter for status/debug.
// - Parametrised successor of the fixed 5-ones detector; sits on the serial-line monitor path.
// PARAMETERS
// - MAX_RUN  default 15  largest supported run length L (>=1)
// - LW       default 4   width of run_len and run counter, >= clog2(MAX_RUN+1)
// - CNT_W    default 8   width of hit_cnt
// PORTS
// - clk      in   1      rising-edge clock
// - rst_n    in   1      asynchronous, active-low reset
// - j        in   1      serial data bit, sampled every clk
// - en       in   1      alarm acknowledge (level, sampled at clk)
// - clr      in   1      synchronous clear of hit_cnt
// - run_len  in   LW     requested run length L
// - w        out  1      alarm, sticky until acknowledged
// - busy     out  1      1 when scan FSM is not IDLE
// - hit_cnt  out  CNT_W  number of detections, saturating
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, run counter=0, L_q=1, w=0, hit_cnt=0. Asserting reset mid-frame aborts the frame.
// - L_q: captured from run_len on every clk while state==IDLE.
//   - run_len=0 clamps to 1; run_len>MAX_RUN clamps to MAX_RUN.
//   - Held constant outside IDLE.
// - Scan FSM (Moore, registered), with rc = run counter:
//   - IDLE:  j=0 -> ZERO; j=1 -> IDLE.
//   - ZERO:  j=0 -> ZERO; j=1 -> COUNT, rc=1.
//   - COUNT, j=1: if rc==L_q -> IDLE (overrun; a fresh 0 is needed); else rc=rc+1.
//   - COUNT, j=0: if rc==L_q -> detection; else -> ZERO, rc=0.
//   - ALARM (non-overlap build only): j ignored. en=1 -> IDLE. en=0 -> hold.
// - Detection event:
//   - w<=1 and hit_cnt<=hit_cnt+1 (sticks at all-ones), both visible the cycle after the terminating 0 is sampled.
//   - Latency: 1 clk from the terminating-0 edge to w=1.
// - w clears the cycle after en=1 is sampled, unless a detection occurs in that same cycle (detection wins, w stays 1).
// - en has no effect while w=0.
// - clr=1: hit_cnt<=0. If clr and a detection occur in the same cycle, hit_cnt<=1.
// - busy = (state!=IDLE), combinational from state.
// - rc never exceeds L_q. No wrap of rc is possible.
// CONFIGURATION
// - Macro DETECT_OVERLAP_EN.
// - Undefined (default):
//   - Detection -> ALARM state. Scanning stalls until ack. Frames during ALARM are not counted.
//   - After ack: IDLE, so a new leading 0 is needed.
// - Defined:
//   - No ALARM state. Detection -> ZERO, rc=0, so the terminating 0 also serves as the next leading 0.
//   - w is a separate sticky flag; scanning continues while w=1, and further hits increment hit_cnt.
//   - busy reflects only the scan FSM.
// TESTING
// - Reset: rst_n=0 mid-COUNT, asynchronously -> w=0, busy=0, hit_cnt=0 immediately, without waiting for a clk edge.
// - L=5, j=0,1,1,1,1,1,0 -> w=1 one clk after the last 0; hit_cnt=1. en=1 -> w=0 next clk.
// - L=5, j=0,1x6,0 -> no alarm (overrun to IDLE). j=0,1x4,0 -> no alarm (back to ZERO).
// - run_len=0 -> L=1: j=0,1,0 -> w=1. run_len=20 (MAX_RUN=15) -> detects only 0,1x15,0.
// - Saturation: CNT_W=2, 5 acked detections -> hit_cnt=3. clr with a simultaneous hit -> hit_cnt=1.
// - Frames "0,1,1,1,0,1,1,1,0", L=3:
//   - Default build: hit_cnt=1, w held until en.
//   - DETECT_OVERLAP_EN build: hit_cnt=2; en coincident with 2nd hit -> w stays 1.

Source files
------------

// File: rtl/run_length_detector.sv
// Serial "0, exactly L ones, 0" frame detector with a sticky alarm and a saturating hit counter.
// Optional build macro DETECT_OVERLAP_EN: no ALARM stall, so the terminating 0 restarts the scan.
module run_length_detector #(
  parameter int MAX_RUN = 15,
  parameter int LW      = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             j,
  input  logic             en,
  input  logic             clr,
  input  logic [LW-1:0]    run_len,
  output logic             w,
  output logic             busy,
  output logic [CNT_W-1:0] hit_cnt
);

`ifdef DETECT_OVERLAP_EN
  typedef enum logic [1:0] {IDLE, ZERO, COUNT} state_e;
`else
  typedef enum logic [1:0] {IDLE, ZERO, COUNT, ALARM} state_e;
`endif

  state_e           state_q, state_d;
  logic [LW-1:0]    rc_q, rc_d;
  logic [LW-1:0]    len_q, len_d;
  logic             w_q, w_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [LW-1:0]    len_clamped;
  logic             det;

  always_comb begin
    len_clamped = run_len;
    if (run_len == '0) begin
      len_clamped = LW'(1);
    end else if (run_len > LW'(MAX_RUN)) begin
      len_clamped = LW'(MAX_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    len_d   = len_q;
    det     = 1'b0;
    case (state_q)
      IDLE: begin
        len_d = len_clamped;
        if (!j) state_d = ZERO;
      end
      ZERO: begin
        if (j) begin
          state_d = COUNT;
          rc_d    = LW'(1);
        end
      end
      COUNT: begin
        if (j) begin
          if (rc_q == len_q) begin
            state_d = IDLE;
            rc_d    = '0;
          end else begin
            rc_d = rc_q + LW'(1);
          end
        end else begin
          rc_d = '0;
          if (rc_q == len_q) begin
            det = 1'b1;
`ifdef DETECT_OVERLAP_EN
            state_d = ZERO;
`else
            state_d = ALARM;
`endif
          end else begin
            state_d = ZERO;
          end
        end
      end
`ifndef DETECT_OVERLAP_EN
      ALARM: begin
        if (en) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // A detection in the acknowledge cycle keeps the alarm raised.
  always_comb begin
    w_d = w_q;
    if (det) begin
      w_d = 1'b1;
    end else if (en && w_q) begin
      w_d = 1'b0;
    end
  end

  always_comb begin
    hit_d = hit_q;
    if (det) begin
      if (clr)             hit_d = CNT_W'(1);
      else if (hit_q != '1) hit_d = hit_q + CNT_W'(1);
    end else if (clr) begin
      hit_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rc_q    <= '0;
      len_q   <= LW'(1);
      w_q     <= 1'b0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      len_q   <= len_d;
      w_q     <= w_d;
      hit_q   <= hit_d;
    end
  end

  assign w       = w_q;
  assign busy    = (state_q != IDLE);
  assign hit_cnt = hit_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench for run_length_detector; a second instance with a 2-bit counter covers saturation.
module tb_run_length_detector;

  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          j, en, clr;
  logic [LW-1:0] run_len;
  logic          w, busy, w_s, busy_s;
  logic [7:0]    hit;
  logic [1:0]    hit_s;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  run_length_detector #(.MAX_RUN(15), .LW(LW), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .j(j), .en(en), .clr(clr), .run_len(run_len),
    .w(w), .busy(busy), .hit_cnt(hit)
  );

  run_length_detector #(.MAX_RUN(15), .LW(LW), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .j(j), .en(en), .clr(clr), .run_len(run_len),
    .w(w_s), .busy(busy_s), .hit_cnt(hit_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic jv, input logic env, input logic clrv);
    j   = jv;
    en  = env;
    clr = clrv;
    @(posedge clk);
    #1;
  endtask

  // Holding j=1 with en=1 acknowledges any alarm and returns both scanners to IDLE.
  task automatic flush();
    repeat (20) step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic frame(input string tag, input int ones, input logic clr_last, input logic exp_w);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < ones; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, clr_last);
    check({tag, "_w"}, 32'(w), 32'(exp_w));
    check({tag, "_w_s"}, 32'(w_s), 32'(exp_w));
  endtask

  initial begin
    rst_n   = 1'b0;
    j       = 1'b1;
    en      = 1'b0;
    clr     = 1'b0;
    run_len = LW'(5);
    repeat (2) @(posedge clk);
    #1;
    check("rst_w", 32'(w), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    rst_n = 1'b1;
    flush();
    check("idle_busy", 32'(busy), 32'd0);

    // L=5 exact frame
    frame("l5_hit", 5, 1'b0, 1'b1);
    check("l5_hit_cnt", 32'(hit), 32'd1);
    check("l5_busy", 32'(busy), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    check("l5_ack", 32'(w), 32'd0);
    flush();
    check("l5_idle", 32'(busy), 32'd0);

    // Overrun and short run
    frame("l5_over", 6, 1'b0, 1'b0);
    frame("l5_short", 4, 1'b0, 1'b0);
    check("l5_miss_cnt", 32'(hit), 32'd1);
    flush();

    // run_len=0 clamps to 1
    run_len = LW'(0);
    flush();
    frame("l1_hit", 1, 1'b0, 1'b1);
    check("l1_cnt", 32'(hit), 32'd2);
    flush();

    // run_len=20 clamps to 15
    run_len = LW'(20);
    flush();
    frame("l15_14", 14, 1'b0, 1'b0);
    frame("l15_15", 15, 1'b0, 1'b1);
    check("l15_cnt", 32'(hit), 32'd3);
    flush();
    frame("l15_16", 16, 1'b0, 1'b0);
    flush();

    // Clear, saturation, clear with simultaneous hit
    step(1'b1, 1'b0, 1'b1);
    check("clr_hit", 32'(hit), 32'd0);
    check("clr_hit_s", 32'(hit_s), 32'd0);
    run_len = LW'(1);
    flush();
    for (int k = 0; k < 5; k++) begin
      frame("sat_frame", 1, 1'b0, 1'b1);
      flush();
    end
    check("sat_hit8", 32'(hit), 32'd5);
    check("sat_hit2", 32'(hit_s), 32'd3);
    frame("clrhit", 1, 1'b1, 1'b1);
    check("clrhit_cnt", 32'(hit), 32'd1);
    check("clrhit_cnt_s", 32'(hit_s), 32'd1);
    flush();

    // Back-to-back frames sharing the middle 0, L=3
    step(1'b1, 1'b0, 1'b1);
    run_len = LW'(3);
    flush();
    step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("b2b_w1", 32'(w), 32'd1);
    check("b2b_cnt1", 32'(hit), 32'd1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
`ifdef DETECT_OVERLAP_EN
    step(1'b0, 1'b1, 1'b0);
    check("b2b_w2", 32'(w), 32'd1);
    check("b2b_cnt2", 32'(hit), 32'd2);
    step(1'b1, 1'b1, 1'b0);
    check("b2b_ack", 32'(w), 32'd0);
`else
    step(1'b0, 1'b0, 1'b0);
    check("b2b_w2", 32'(w), 32'd1);
    check("b2b_cnt2", 32'(hit), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    check("b2b_ack", 32'(w), 32'd0);
    check("b2b_idle", 32'(busy), 32'd0);
`endif
    flush();

    // Asynchronous reset in the middle of a run
    run_len = LW'(5);
    flush();
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_w", 32'(w), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hit", 32'(hit), 32'd0);
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
